// File: rtl/adc_dac_bridge.sv
`default_nettype none
// ============================================================================
// Module      : adc_dac_bridge
// Description : ADC-capture / DAC-drive bridge for the AD9481 -> FIR -> AD9764
//               path, running entirely on CLK_250M.
//               - Captures CH ADC channels and removes a programmable offset
//                 (modulo arithmetic, result read as two's complement).
//               - Decimates the capture stream to a sample strobe for the FIR.
//               - Hysteresis comparator on channel 0, with optional period
//                 measurement between comparator rising edges.
//               - Formats the FIR result and the comparator/channel-1 data
//                 into inverted offset-binary, left-aligned DAC words.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option: ADC_DAC_PERIOD_EN
//               defined   -> armed flag, period counter, period/period_valid
//               undefined -> period tied to 0, period_valid tied to 0
// ----------------------------------------------------------------------------
// Ports
//   CLK_250M      in   1          system clock
//   RST_n         in   1          synchronous, active-low reset
//   adc_data      in   CH*ADC_W   raw offset-binary samples, ch k at [k*ADC_W +: ADC_W]
//   adc_offset    in   ADC_W      subtracted from every channel
//   pdn_req       in   1          ADC power-down request
//   filt_data     in   ADC_W      FIR result, two's complement
//   filt_valid    in   1          filt_data qualifier
//   dac_b_sel     in   1          0: DAC B shows comparator, 1: channel 1
//   PDN           out  1          registered pdn_req
//   cap_data      out  CH*ADC_W   offset-removed samples, two's complement
//   sample_stb    out  1          one-cycle strobe every DECIM cycles
//   dec_data      out  ADC_W      channel-0 capture latched with sample_stb
//   cmp_out       out  1          hysteresis comparator output
//   period        out  PER_W      cycles between cmp_out rising edges
//   period_valid  out  1          one-cycle strobe when period updates
//   dac_a, dac_b  out  DAC_W      DAC words
//   DA_CLKA/B     out  1          copies of CLK_250M
// ============================================================================
module adc_dac_bridge #(
   parameter int ADC_W = 8,
   parameter int DAC_W = 14,
   parameter int CH    = 2,
   parameter int DECIM = 5,
   parameter int HYST  = 4,
   parameter int PER_W = 24
) (
   input  logic                  CLK_250M,
   input  logic                  RST_n,
   input  logic [CH*ADC_W-1:0]   adc_data,
   input  logic [ADC_W-1:0]      adc_offset,
   input  logic                  pdn_req,
   input  logic [ADC_W-1:0]      filt_data,
   input  logic                  filt_valid,
   input  logic                  dac_b_sel,
   output logic                  PDN,
   output logic [CH*ADC_W-1:0]   cap_data,
   output logic                  sample_stb,
   output logic [ADC_W-1:0]      dec_data,
   output logic                  cmp_out,
   output logic [PER_W-1:0]      period,
   output logic                  period_valid,
   output logic [DAC_W-1:0]      dac_a,
   output logic [DAC_W-1:0]      dac_b,
   output logic                  DA_CLKA,
   output logic                  DA_CLKB
);

   localparam int                    c_dec_cw   = $clog2(DECIM);
   localparam logic [c_dec_cw-1:0]   c_dec_last = c_dec_cw'(DECIM - 1);
   localparam logic [ADC_W-1:0]      c_adc_half = {1'b1, {(ADC_W-1){1'b0}}};
   localparam logic [DAC_W-1:0]      c_dac_mid  = {1'b1, {(DAC_W-1){1'b0}}};
   // One extra bit so that +HYST / -HYST never alias in the sample domain.
   localparam logic signed [ADC_W:0] c_hyst_pos = (ADC_W+1)'(HYST);
   localparam logic signed [ADC_W:0] c_hyst_neg = -c_hyst_pos;

   logic                   r_pdn;
   logic [CH*ADC_W-1:0]    r_cap;
   logic [CH*ADC_W-1:0]    w_cap_nxt;
   logic [c_dec_cw-1:0]    r_dec_cnt;
   logic                   r_stb;
   logic [ADC_W-1:0]       r_dec;
   logic                   r_cmp;
   logic                   w_cmp_nxt;
   logic signed [ADC_W:0]  w_s;
   logic [DAC_W-1:0]       r_dac_a;
   logic [DAC_W-1:0]       r_dac_b;
   logic [DAC_W-1:0]       w_dac_a_word;
   logic [DAC_W-1:0]       w_dac_b_word;

   // Offset removal wraps modulo 2^ADC_W on purpose; no saturation.
   for (genvar k = 0; k < CH; k++) begin : g_cap
      assign w_cap_nxt[k*ADC_W +: ADC_W] = adc_data[k*ADC_W +: ADC_W] - adc_offset;
   end

   // Sign-extended channel-0 sample for the comparator thresholds.
   assign w_s = {r_cap[ADC_W-1], r_cap[ADC_W-1:0]};

   always_comb begin
      w_cmp_nxt = r_cmp;
      if (w_s > c_hyst_pos) begin
         w_cmp_nxt = 1'b1;
      end else if (w_s < c_hyst_neg) begin
         w_cmp_nxt = 1'b0;
      end
   end

   // Adding half-scale converts two's complement to offset-binary; the DAC
   // front end is inverting, hence the complement. Low bits stay zero.
   always_comb begin
      w_dac_a_word                     = '0;
      w_dac_a_word[DAC_W-1 -: ADC_W]   = ~(filt_data + c_adc_half);
      w_dac_b_word                     = '0;
      if (dac_b_sel) begin
         w_dac_b_word[DAC_W-1 -: ADC_W] = ~(r_cap[ADC_W +: ADC_W] + c_adc_half);
      end else begin
         w_dac_b_word[DAC_W-1] = ~r_cmp;
      end
   end

   always_ff @(posedge CLK_250M) begin
      if (!RST_n) begin
         r_pdn     <= 1'b0;
         r_cap     <= '0;
         r_dec_cnt <= '0;
         r_stb     <= 1'b0;
         r_dec     <= '0;
         r_cmp     <= 1'b0;
         r_dac_a   <= c_dac_mid;
         r_dac_b   <= c_dac_mid;
      end else begin
         r_pdn <= pdn_req;
         r_cap <= w_cap_nxt;
         // Strobe is registered off the terminal count, so it first appears
         // DECIM edges after reset release.
         if (r_dec_cnt == c_dec_last) begin
            r_dec_cnt <= '0;
            r_stb     <= 1'b1;
            r_dec     <= r_cap[ADC_W-1:0];
         end else begin
            r_dec_cnt <= r_dec_cnt + c_dec_cw'(1);
            r_stb     <= 1'b0;
         end
         r_cmp <= w_cmp_nxt;
         if (filt_valid) begin
            r_dac_a <= w_dac_a_word;
         end
         r_dac_b <= w_dac_b_word;
      end
   end

`ifdef ADC_DAC_PERIOD_EN
   logic             r_cmp_d;
   logic             r_armed;
   logic             r_pv;
   logic [PER_W-1:0] r_per_cnt;
   logic [PER_W-1:0] r_period;
   logic [PER_W-1:0] w_per_inc;
   logic             w_rise;

   assign w_rise    = r_cmp & ~r_cmp_d;
   // Saturating increment: a stuck comparator reports the maximum period.
   assign w_per_inc = (&r_per_cnt) ? r_per_cnt : r_per_cnt + PER_W'(1);

   always_ff @(posedge CLK_250M) begin
      if (!RST_n) begin
         r_cmp_d   <= 1'b0;
         r_armed   <= 1'b0;
         r_pv      <= 1'b0;
         r_per_cnt <= '0;
         r_period  <= '0;
      end else begin
         r_cmp_d <= r_cmp;
         r_pv    <= 1'b0;
         if (w_rise) begin
            r_per_cnt <= '0;
            r_armed   <= 1'b1;
            // The first edge after reset only starts the measurement.
            if (r_armed) begin
               r_period <= w_per_inc;
               r_pv     <= 1'b1;
            end
         end else begin
            r_per_cnt <= w_per_inc;
         end
      end
   end

   assign period       = r_period;
   assign period_valid = r_pv;
`else
   assign period       = '0;
   assign period_valid = 1'b0;
`endif

   assign PDN        = r_pdn;
   assign cap_data   = r_cap;
   assign sample_stb = r_stb;
   assign dec_data   = r_dec;
   assign cmp_out    = r_cmp;
   assign dac_a      = r_dac_a;
   assign dac_b      = r_dac_b;
   assign DA_CLKA    = CLK_250M;
   assign DA_CLKB    = CLK_250M;

endmodule
`default_nettype wire

// File: tb/tb_adc_dac_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_adc_dac_bridge
// Description : Self-checking bench for adc_dac_bridge. Expected values are
//               queued with their due cycle when stimulus is applied and are
//               compared when that cycle is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_dac_bridge;

   localparam int ADC_W = 8;
   localparam int DAC_W = 14;
   localparam int CH    = 2;
   localparam int DECIM = 5;
   localparam int HYST  = 4;
   localparam int PER_W = 24;

`ifdef ADC_DAC_PERIOD_EN
   localparam bit PER_EN = 1'b1;
`else
   localparam bit PER_EN = 1'b0;
`endif

   localparam int S_PDN  = 0;
   localparam int S_CAP0 = 1;
   localparam int S_CAP1 = 2;
   localparam int S_STB  = 3;
   localparam int S_DEC  = 4;
   localparam int S_CMP  = 5;
   localparam int S_PER  = 6;
   localparam int S_PV   = 7;
   localparam int S_DACA = 8;
   localparam int S_DACB = 9;
   localparam int S_CLKA = 10;
   localparam int S_CLKB = 11;

   logic                 CLK_250M = 1'b0;
   logic                 RST_n;
   logic [CH*ADC_W-1:0]  adc_data;
   logic [ADC_W-1:0]     adc_offset;
   logic                 pdn_req;
   logic [ADC_W-1:0]     filt_data;
   logic                 filt_valid;
   logic                 dac_b_sel;
   logic                 PDN;
   logic [CH*ADC_W-1:0]  cap_data;
   logic                 sample_stb;
   logic [ADC_W-1:0]     dec_data;
   logic                 cmp_out;
   logic [PER_W-1:0]     period;
   logic                 period_valid;
   logic [DAC_W-1:0]     dac_a;
   logic [DAC_W-1:0]     dac_b;
   logic                 DA_CLKA;
   logic                 DA_CLKB;

   always #2 CLK_250M = ~CLK_250M;

   adc_dac_bridge #(
      .ADC_W(ADC_W), .DAC_W(DAC_W), .CH(CH), .DECIM(DECIM), .HYST(HYST), .PER_W(PER_W)
   ) dut (
      .CLK_250M     (CLK_250M),
      .RST_n        (RST_n),
      .adc_data     (adc_data),
      .adc_offset   (adc_offset),
      .pdn_req      (pdn_req),
      .filt_data    (filt_data),
      .filt_valid   (filt_valid),
      .dac_b_sel    (dac_b_sel),
      .PDN          (PDN),
      .cap_data     (cap_data),
      .sample_stb   (sample_stb),
      .dec_data     (dec_data),
      .cmp_out      (cmp_out),
      .period       (period),
      .period_valid (period_valid),
      .dac_a        (dac_a),
      .dac_b        (dac_b),
      .DA_CLKA      (DA_CLKA),
      .DA_CLKB      (DA_CLKB)
   );

   typedef struct {
      int          due;
      int          sig;
      logic [31:0] exp;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   function automatic logic [31:0] obs(int sig);
      logic [31:0] r;
      r = 32'hDEAD_BEEF;
      case (sig)
         S_PDN:  r = 32'(PDN);
         S_CAP0: r = 32'(cap_data[7:0]);
         S_CAP1: r = 32'(cap_data[15:8]);
         S_STB:  r = 32'(sample_stb);
         S_DEC:  r = 32'(dec_data);
         S_CMP:  r = 32'(cmp_out);
         S_PER:  r = 32'(period);
         S_PV:   r = 32'(period_valid);
         S_DACA: r = 32'(dac_a);
         S_DACB: r = 32'(dac_b);
         S_CLKA: r = 32'(DA_CLKA);
         S_CLKB: r = 32'(DA_CLKB);
         default: r = 32'hDEAD_BEEF;
      endcase
      return r;
   endfunction

   // Inverted offset-binary, left-aligned: flipping the MSB is the same as
   // adding half scale.
   function automatic logic [13:0] dac_fmt(logic [7:0] x);
      return {~(x ^ 8'h80), 6'b000000};
   endfunction

   task automatic expect_at(int lat, int sig, logic [31:0] exp, string tag);
      exp_t e;
      e.due = cyc + lat;
      e.sig = sig;
      e.exp = exp;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic check_due();
      exp_t        keep[$];
      logic [31:0] o;
      foreach (sb[i]) begin
         if (sb[i].due <= cyc) begin
            o = obs(sb[i].sig);
            checks++;
            assert (o === sb[i].exp) else begin
               errors++;
               $error("FAIL %s cycle %0d: observed %0h expected %0h", sb[i].tag, cyc, o, sb[i].exp);
            end
         end else begin
            keep.push_back(sb[i]);
         end
      end
      sb = keep;
   endtask

   task automatic tick();
      @(posedge CLK_250M);
      #1;
      cyc++;
      check_due();
   endtask

   task automatic check_reset(string tag);
      expect_at(0, S_PDN,  32'h0,    {tag, "_pdn"});
      expect_at(0, S_CAP0, 32'h0,    {tag, "_cap0"});
      expect_at(0, S_CAP1, 32'h0,    {tag, "_cap1"});
      expect_at(0, S_STB,  32'h0,    {tag, "_stb"});
      expect_at(0, S_DEC,  32'h0,    {tag, "_dec"});
      expect_at(0, S_CMP,  32'h0,    {tag, "_cmp"});
      expect_at(0, S_PER,  32'h0,    {tag, "_period"});
      expect_at(0, S_PV,   32'h0,    {tag, "_pvalid"});
      expect_at(0, S_DACA, 32'h2000, {tag, "_daca"});
      expect_at(0, S_DACB, 32'h2000, {tag, "_dacb"});
      expect_at(0, S_CLKA, 32'h1,    {tag, "_clka"});
      expect_at(0, S_CLKB, 32'h1,    {tag, "_clkb"});
      check_due();
   endtask

   // Square wave on channel 0 (+20 / -20 around offset 127): 50 low cycles,
   // then nper periods of 100 cycles, then a low tail. A drive change reaches
   // cmp_out after 2 edges and period_valid after 3.
   task automatic square_wave(int nper, string tag);
      bit armed;
      bit level;
      bit prev;
      int total;
      armed      = 1'b0;
      prev       = 1'b0;
      adc_offset = 8'd127;
      total      = 50 + nper * 100 + 10;
      for (int k = 0; k < total; k++) begin
         level = (k >= 50) && (k < 50 + nper * 100) && (((k - 50) % 100) < 50);
         adc_data[7:0] = level ? 8'd147 : 8'd107;
         if (level && !prev) begin
            expect_at(3, S_PV,  (PER_EN && armed) ? 32'd1   : 32'd0, {tag, "_pv_edge"});
            expect_at(3, S_PER, (PER_EN && armed) ? 32'd100 : 32'd0, {tag, "_period"});
            armed = 1'b1;
         end else begin
            expect_at(3, S_PV, 32'd0, {tag, "_pv_idle"});
         end
         prev = level;
         tick();
      end
      repeat (3) tick();
   endtask

   initial begin
      logic [7:0] v;
      logic [7:0] c;
      logic [7:0] o;
      logic [7:0] a0;
      logic [7:0] a1;
      logic [7:0] f;
      int         s_seq [7];
      int         cmp_seq [7];
      s_seq   = '{0, 5, 3, -3, -5, 4, 5};
      cmp_seq = '{0, 1, 1, 1, 0, 0, 1};

      // Reset held for 3 cycles with random inputs.
      RST_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         adc_data   = 16'($urandom_range(65535));
         adc_offset = 8'($urandom_range(255));
         pdn_req    = 1'($urandom_range(1));
         filt_data  = 8'($urandom_range(255));
         filt_valid = 1'($urandom_range(1));
         dac_b_sel  = 1'($urandom_range(1));
         tick();
      end
      check_reset("reset");

      // Decimation: counted from reset release (cycle n = n-th edge after).
      adc_offset = 8'd127;
      pdn_req    = 1'b0;
      filt_valid = 1'b0;
      dac_b_sel  = 1'b0;
      RST_n      = 1'b1;
      for (int n = 0; n < 15; n++) begin
         v = 8'($urandom_range(255));
         adc_data[7:0] = v;
         c = v - 8'd127;
         expect_at(1, S_STB, ((n + 1) % DECIM == 0) ? 32'd1 : 32'd0, "dec_stb");
         expect_at(1, S_CAP0, 32'(c), "dec_cap0");
         if ((n + 2) % DECIM == 0) begin
            expect_at(2, S_DEC, 32'(c), "dec_data");
         end
         tick();
      end
      tick();

      // Offset removal with wrap.
      adc_offset = 8'd127;
      adc_data   = {8'h7F, 8'h00};
      expect_at(1, S_CAP0, 32'h81, "wrap_ch0_00");
      expect_at(1, S_CAP1, 32'h00, "wrap_ch1_7f");
      tick();
      adc_data = {8'h80, 8'hFF};
      expect_at(1, S_CAP0, 32'h80, "wrap_ch0_ff");
      expect_at(1, S_CAP1, 32'h01, "wrap_ch1_80");
      tick();
      for (int i = 0; i < 4; i++) begin
         o  = 8'($urandom_range(255));
         a0 = 8'($urandom_range(255));
         a1 = 8'($urandom_range(255));
         adc_offset = o;
         adc_data   = {a1, a0};
         c = a0 - o;
         expect_at(1, S_CAP0, 32'(c), "cap_rand_ch0");
         c = a1 - o;
         expect_at(1, S_CAP1, 32'(c), "cap_rand_ch1");
         tick();
      end

      // Power-down follows request one edge later.
      pdn_req = 1'b1;
      expect_at(1, S_PDN, 32'h1, "pdn_high");
      tick();
      pdn_req = 1'b0;
      expect_at(1, S_PDN, 32'h0, "pdn_low");
      tick();

      // Hysteresis comparator, DAC B showing the comparator.
      adc_offset    = 8'd127;
      dac_b_sel     = 1'b0;
      adc_data[7:0] = 8'd117;
      repeat (3) tick();
      expect_at(0, S_CMP, 32'h0, "hyst_pre");
      check_due();
      for (int i = 0; i < 7; i++) begin
         adc_data[7:0] = 8'(s_seq[i] + 127);
         expect_at(2, S_CMP, 32'(cmp_seq[i]), "hyst_cmp");
         expect_at(3, S_DACB, (cmp_seq[i] != 0) ? 32'h0000 : 32'h2000, "hyst_dacb");
         tick();
      end
      repeat (3) tick();

      // DAC A formatting.
      filt_data  = 8'h00;
      filt_valid = 1'b1;
      expect_at(1, S_DACA, 32'h1FC0, "daca_zero");
      tick();
      filt_valid = 1'b0;
      filt_data  = 8'h55;
      expect_at(1, S_DACA, 32'h1FC0, "daca_hold");
      tick();
      filt_valid = 1'b1;
      filt_data  = 8'h7F;
      expect_at(1, S_DACA, 32'h0000, "daca_pos_max");
      tick();
      filt_data = 8'h80;
      expect_at(1, S_DACA, 32'h3FC0, "daca_neg_max");
      tick();
      for (int i = 0; i < 3; i++) begin
         f = 8'($urandom_range(255));
         filt_data = f;
         expect_at(1, S_DACA, 32'(dac_fmt(f)), "daca_rand");
         tick();
      end
      filt_valid = 1'b0;
      tick();

      // DAC B showing channel 1, then switching back to the comparator.
      adc_offset    = 8'd127;
      adc_data[7:0] = 8'd147;
      dac_b_sel     = 1'b1;
      for (int i = 0; i < 4; i++) begin
         v = 8'($urandom_range(255));
         adc_data[15:8] = v;
         c = v - 8'd127;
         expect_at(2, S_DACB, 32'(dac_fmt(c)), "dacb_ch1");
         tick();
      end
      tick();
      dac_b_sel = 1'b0;
      expect_at(1, S_DACB, 32'h0000, "dacb_cmp_high");
      tick();
      adc_data[7:0] = 8'd107;
      expect_at(3, S_DACB, 32'h2000, "dacb_cmp_low");
      repeat (3) tick();

      // Period measurement from a fresh reset.
      RST_n = 1'b0;
      tick();
      check_reset("per_reset");
      RST_n = 1'b1;
      square_wave(4, "per_a");

      // Reset in the middle of a high phase clears the measurement.
      adc_data[7:0] = 8'd147;
      repeat (30) tick();
      RST_n = 1'b0;
      adc_data[7:0] = 8'd107;
      tick();
      check_reset("mid_reset");
      RST_n = 1'b1;
      square_wave(2, "per_b");

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
